sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter.sv | 133 +++++++++++++
 tb/tb_sqrt_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt unit among NREQ requesters.
// Optional BUSY watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   operand,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          resp_result,
  output logic                 resp_cflag,
  output logic                 resp_oflag,
  output logic                 resp_err,
  output logic                 sqrt_start,
  output logic [31:0]          sqrt_nr,
  input  logic                 sqrt_ready,
  input  logic [15:0]          sqrt_result,
  input  logic                 sqrt_cflag,
  input  logic                 sqrt_oflag
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   last_grant_q;
  logic [GW-1:0]   winner_q;
  logic [GW-1:0]   winner_d;
  logic            found;
  int              cand;

`ifdef SQRT_ARB_TIMEOUT_EN
  logic [15:0]     wd_q;
`endif

  // Round-robin search starting just after the last grant, wrapping once.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    winner_d = last_grant_q;
    found    = 1'b0;
    cand     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        winner_d = GW'(cand);
        found    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is reset, including the datapath, so the
      // response bus and sqrt_nr are defined straight out of reset.
      state_q      <= IDLE;
      last_grant_q <= GW'(NREQ - 1);
      winner_q     <= '0;
      sqrt_start   <= 1'b0;
      sqrt_nr      <= '0;
      ack          <= '0;
      done         <= '0;
      resp_result  <= '0;
      resp_cflag   <= 1'b0;
      resp_oflag   <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
      resp_err     <= 1'b0;
      wd_q         <= '0;
`endif
    end else begin
      ack  <= '0;
      done <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            winner_q     <= winner_d;
            last_grant_q <= winner_d;
            sqrt_nr      <= operand[32*winner_d +: 32];
            ack          <= NREQ'(1) << winner_d;
            sqrt_start   <= 1'b1;
            state_q      <= BUSY;
`ifdef SQRT_ARB_TIMEOUT_EN
            wd_q         <= '0;
`endif
          end
        end
        BUSY: begin
          if (sqrt_ready) begin
            resp_result <= sqrt_result;
            resp_cflag  <= sqrt_cflag;
            resp_oflag  <= sqrt_oflag;
            done        <= NREQ'(1) << winner_q;
            sqrt_start  <= 1'b0;
            state_q     <= RECOVER;
`ifdef SQRT_ARB_TIMEOUT_EN
            resp_err    <= 1'b0;
          end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog expiry: report an error response to the winner.
            resp_result <= '0;
            resp_cflag  <= 1'b0;
            resp_oflag  <= 1'b0;
            resp_err    <= 1'b1;
            done        <= NREQ'(1) << winner_q;
            sqrt_start  <= 1'b0;
            state_q     <= RECOVER;
          end else begin
            wd_q        <= wd_q + 16'd1;
`endif
          end
        end
        RECOVER: state_q <= IDLE;
        default: begin
          state_q    <= IDLE;
          sqrt_start <= 1'b0;
        end
      endcase
    end
  end

`ifndef SQRT_ARB_TIMEOUT_EN
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed self-checking bench for sqrt_arbiter with a behavioural sqrt stub.
// Watchdog steps run only when SQRT_ARB_TIMEOUT_EN is defined.
module tb_sqrt_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] operand;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic [15:0]       resp_result;
  logic              resp_cflag;
  logic              resp_oflag;
  logic              resp_err;
  logic              sqrt_start;
  logic [31:0]       sqrt_nr;
  logic              sqrt_ready;
  logic [15:0]       sqrt_result;
  logic              sqrt_cflag;
  logic              sqrt_oflag;

  int n_checks = 0;
  int n_fail   = 0;

  sqrt_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .operand     (operand),
    .ack         (ack),
    .done        (done),
    .resp_result (resp_result),
    .resp_cflag  (resp_cflag),
    .resp_oflag  (resp_oflag),
    .resp_err    (resp_err),
    .sqrt_start  (sqrt_start),
    .sqrt_nr     (sqrt_nr),
    .sqrt_ready  (sqrt_ready),
    .sqrt_result (sqrt_result),
    .sqrt_cflag  (sqrt_cflag),
    .sqrt_oflag  (sqrt_oflag)
  );

  always #5 clk = ~clk;

  // Sqrt unit stub: ready after stub_lat BUSY cycles unless stub_hold.
  logic stub_hold;
  int   stub_lat;
  int   stub_cnt;

  function automatic logic [15:0] isqrt(input logic [31:0] n);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (32'(t) * 32'(t) <= n) r = t;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!sqrt_start) stub_cnt <= 0;
    else             stub_cnt <= stub_cnt + 1;
  end

  assign sqrt_ready  = sqrt_start && !stub_hold && (stub_cnt >= stub_lat);
  assign sqrt_result = isqrt(sqrt_nr[31] ? (~sqrt_nr + 32'd1) : sqrt_nr);
  assign sqrt_cflag  = sqrt_nr[31];
  assign sqrt_oflag  = sqrt_nr[31] & sqrt_nr[30];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_ack(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (ack == '0 && cycles < 50);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done == '0 && cycles < 60);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cyc;
  logic seen;
  logic [15:0] exp_res [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
  int          grant_seq [3] = '{2, 0, 2};
  logic [15:0] grant_res [3] = '{16'd6, 16'd5, 16'd6};

  initial begin
    rst = 1'b1; req = '0; operand = '0; stub_hold = 1'b0; stub_lat = 2;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_start", 32'(sqrt_start), 0);
    check("rst_nr", sqrt_nr, 0);
    check("rst_result", 32'(resp_result), 0);
    check("rst_flags", {29'd0, resp_cflag, resp_oflag, resp_err}, 0);
    rst = 1'b0;

    // Single requester, operand 64.
    operand[31:0] = 32'd64; req = 4'b0001;
    wait_ack(cyc);
    check("single_ack_lat", cyc, 1);
    check("single_ack", 32'(ack), 1);
    check("single_nr", sqrt_nr, 64);
    check("single_start", 32'(sqrt_start), 1);
    req = '0;
    wait_done(cyc);
    check("single_done_lat", cyc, 3);
    check("single_done", 32'(done), 1);
    check("single_result", 32'(resp_result), 8);
    check("single_err", 32'(resp_err), 0);
    check("single_cflag", 32'(resp_cflag), 0);
    check("recover_start", 32'(sqrt_start), 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("resp_hold", 32'(resp_result), 8);

    // All four requesting: grants 0,1,2,3 from reset.
    do_reset();
    operand = {32'd16, 32'd9, 32'd4, 32'd1}; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(cyc);
      if (i > 0) check("rr_spacing", cyc, 2);
      check("rr_ack", 32'(ack), 32'(1) << i);
      check("rr_nr", sqrt_nr, 32'(exp_res[i]) * 32'(exp_res[i]));
      req[i] = 1'b0;
      wait_done(cyc);
      check("rr_done", 32'(done), 32'(1) << i);
      check("rr_result", 32'(resp_result), 32'(exp_res[i]));
    end

    // Fairness: after grant 0, 0101 held alternates 2,0,2.
    do_reset();
    operand = {32'd0, 32'd36, 32'd0, 32'd25}; req = 4'b0001;
    wait_ack(cyc);
    check("fair_first", 32'(ack), 1);
    req = 4'b0101;
    wait_done(cyc);
    check("fair_first_res", 32'(resp_result), 5);
    for (int i = 0; i < 3; i++) begin
      wait_ack(cyc);
      check("fair_spacing", cyc, 2);
      check("fair_ack", 32'(ack), 32'(1) << grant_seq[i]);
      if (i == 2) req = '0;
      wait_done(cyc);
      check("fair_done", 32'(done), 32'(1) << grant_seq[i]);
      check("fair_result", 32'(resp_result), 32'(grant_res[i]));
    end

    // Requester 1 drops its request before being acked.
    do_reset();
    operand = {32'd0, 32'd0, 32'd81, 32'd49}; req = 4'b0001;
    wait_ack(cyc);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_done(cyc);
    check("drop_result", 32'(resp_result), 7);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0 || done != '0 || sqrt_start) seen = 1'b1;
    end
    check("drop_no_grant", 32'(seen), 0);

    // Negative operand: flags follow the sqrt unit.
    operand[31:0] = 32'hFFFF_FFC0; req = 4'b0001;
    wait_ack(cyc);
    req = '0;
    wait_done(cyc);
    check("neg_cflag", 32'(resp_cflag), 1);
    check("neg_oflag", 32'(resp_oflag), 1);
    check("neg_result", 32'(resp_result), 8);

    // Ready on the very first BUSY cycle.
    stub_lat = 0; operand[31:0] = 32'd9; req = 4'b0001;
    wait_ack(cyc);
    req = '0;
    wait_done(cyc);
    check("fast_done_lat", cyc, 1);
    check("fast_result", 32'(resp_result), 3);
    stub_lat = 2;

    // Reset three cycles into BUSY, with req asserted during reset.
    stub_hold = 1'b1; operand[31:0] = 32'd100; req = 4'b0001;
    wait_ack(cyc);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 4'b0001;
    @(negedge clk);
    check("abort_start", 32'(sqrt_start), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_done", 32'(done), 0);
    check("abort_nr", sqrt_nr, 0);
    rst = 1'b0; stub_hold = 1'b0;
    wait_ack(cyc);
    check("post_rst_lat", cyc, 1);
    check("post_rst_ack", 32'(ack), 1);
    req = '0;
    wait_done(cyc);
    check("post_rst_result", 32'(resp_result), 10);

`ifdef SQRT_ARB_TIMEOUT_EN
    // Watchdog expiry after 16 BUSY cycles.
    stub_hold = 1'b1; operand[31:0] = 32'd4; req = 4'b0001;
    wait_ack(cyc);
    req = '0;
    wait_done(cyc);
    check("wd_lat", cyc, 16);
    check("wd_done", 32'(done), 1);
    check("wd_err", 32'(resp_err), 1);
    check("wd_result", 32'(resp_result), 0);
    check("wd_flags", {30'd0, resp_cflag, resp_oflag}, 0);
    // Ready on the 16th BUSY cycle beats the watchdog.
    stub_hold = 1'b0; stub_lat = 15; operand[31:0] = 32'd144; req = 4'b0001;
    wait_ack(cyc);
    req = '0;
    wait_done(cyc);
    check("wd_tie_lat", cyc, 16);
    check("wd_tie_err", 32'(resp_err), 0);
    check("wd_tie_result", 32'(resp_result), 12);
    stub_lat = 2;
`else
    // Without the watchdog BUSY waits for ready indefinitely.
    stub_hold = 1'b1; operand[31:0] = 32'd144; req = 4'b0001;
    wait_ack(cyc);
    req = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done != '0 || !sqrt_start) seen = 1'b1;
    end
    check("nowd_wait", 32'(seen), 0);
    stub_hold = 1'b0;
    wait_done(cyc);
    check("nowd_done", 32'(done), 1);
    check("nowd_result", 32'(resp_result), 12);
    check("nowd_err", 32'(resp_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
